// File: rtl/lsu_pkg.sv
// lsu_pkg: shared state encoding, funct3 and fault-cause codes for the load/store unit
package lsu_pkg;
   typedef enum logic [1:0] {IDLE, REQ, RESP, FAULT} state_t;
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [2:0] CAUSE_NONE     = 3'b000;
   localparam logic [2:0] CAUSE_LD_MISAL = 3'b001;
   localparam logic [2:0] CAUSE_ST_MISAL = 3'b010;
   localparam logic [2:0] CAUSE_ILLEGAL  = 3'b011;
   localparam logic [2:0] CAUSE_TIMEOUT  = 3'b100;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: store lane steering/strobes and load byte/half extraction with extension
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  st_funct3,
   input  logic [1:0]  st_off,
   input  logic [31:0] st_data,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   input  logic [2:0]  ld_funct3,
   input  logic [1:0]  ld_off,
   input  logic [31:0] rdata,
   output logic [31:0] ld_data
);
   logic [15:0] sh;
   always_comb begin
      wdata = st_funct3 == F3_B ? {4{st_data[7:0]}} :
              st_funct3 == F3_H ? {2{st_data[15:0]}} : st_data;
      wstrb = st_funct3 == F3_B ? 4'b0001 << st_off :
              st_funct3 == F3_H ? 4'b0011 << st_off : 4'b1111;
      sh = 16'(rdata >> {ld_off, 3'b000});
      ld_data = ld_funct3 == F3_B  ? {{24{sh[7]}}, sh[7:0]} :
                ld_funct3 == F3_H  ? {{16{sh[15]}}, sh} :
                ld_funct3 == F3_BU ? {24'b0, sh[7:0]} :
                ld_funct3 == F3_HU ? {16'b0, sh} : rdata;
   end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store stage driving a valid/ready single-port data memory
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_valid,
   input  logic        ex_is_load,
   input  logic        ex_is_store,
   input  logic [2:0]  ex_funct3,
   input  logic [31:0] ex_addr,
   input  logic [31:0] ex_wdata,
   output logic        busy,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic        done,
   output logic        load_valid,
   output logic [31:0] load_data,
   output logic        fault,
   output logic [2:0]  fault_cause
);
   localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
   state_t state, nxt;
   logic [2:0] f3_q, cause_q, cause_n;
   logic [1:0] off_q;
   logic ld_q, accept, illegal, misal, timeout;
   logic [31:0] cnt, st_wdata, ld_ext;
   logic [3:0] st_wstrb;

   lsu_align u_align (
      .st_funct3(ex_funct3),
      .st_off(ex_addr[1:0]),
      .st_data(ex_wdata),
      .wdata(st_wdata),
      .wstrb(st_wstrb),
      .ld_funct3(f3_q),
      .ld_off(off_q),
      .rdata(mem_rdata),
      .ld_data(ld_ext)
   );

   always_comb begin
      accept = state == IDLE && ex_valid && (ex_is_load || ex_is_store);
      illegal = (ex_is_load && ex_is_store) ||
                (ex_is_load ? !(ex_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU})
                            : !(ex_funct3 inside {F3_B, F3_H, F3_W}));
      misal = (ex_funct3[1:0] == 2'b01 && ex_addr[0]) ||
              (ex_funct3[1:0] == 2'b10 && ex_addr[1:0] != 2'b00);
      // mem_ready takes priority over an expiring timeout
      timeout = TIMEOUT_CYCLES != 0 && !mem_ready && cnt == TO_LAST;
      nxt = state;
      cause_n = cause_q;
      case (state)
         IDLE: if (accept) begin
            nxt = illegal || misal ? FAULT : REQ;
            cause_n = illegal ? CAUSE_ILLEGAL : ex_is_load ? CAUSE_LD_MISAL : CAUSE_ST_MISAL;
         end
         REQ: begin
            nxt = mem_ready ? RESP : timeout ? FAULT : REQ;
            cause_n = timeout ? CAUSE_TIMEOUT : cause_q;
         end
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) state <= rst ? IDLE : nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         f3_q <= '0;
         off_q <= '0;
         ld_q <= 1'b0;
         cause_q <= CAUSE_NONE;
         cnt <= '0;
         mem_we <= 1'b0;
         mem_addr <= '0;
         mem_wdata <= '0;
         mem_wstrb <= '0;
         load_data <= '0;
      end else begin
         cause_q <= cause_n;
         if (accept) begin
            f3_q <= ex_funct3;
            off_q <= ex_addr[1:0];
            ld_q <= ex_is_load;
            mem_we <= ex_is_store && !ex_is_load;
            mem_addr <= {ex_addr[31:2], 2'b00};
            mem_wdata <= st_wdata;
            mem_wstrb <= ex_is_load ? 4'b0000 : st_wstrb;
         end
         cnt <= accept ? '0 : state == REQ && !mem_ready ? cnt + 32'd1 : cnt;
         if (state == REQ && mem_ready && ld_q) load_data <= ld_ext;
      end
   end

   assign busy = state != IDLE;
   assign mem_req = state == REQ;
   assign done = state == RESP;
   assign load_valid = state == RESP && ld_q;
   assign fault = state == FAULT;
   assign fault_cause = state == FAULT ? cause_q : CAUSE_NONE;
endmodule
